// File: rtl/logic_op_pipe.sv
// Two-stage pipelined N-operand bitwise logic unit (OR/AND/XOR/NOR) with valid/ready handshakes.
// Optional registered result parity output when LOGIC_OP_PARITY_EN is defined.
module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count
`ifdef LOGIC_OP_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  logic                    s1_valid_q, s1_valid_d;
  op_e                     s1_op_q, s1_op_d;
  logic [NUM_IN*WIDTH-1:0] s1_data_q, s1_data_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]        s2_data_q, s2_data_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    s1_adv, s2_adv, s2_load;
  logic [WIDTH-1:0]        or_red, and_red, xor_red, result;

  // Column-wise reduction of the operands held in S1
  always_comb begin
    or_red  = '0;
    and_red = '1;
    xor_red = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      or_red  = or_red  | s1_data_q[k*WIDTH +: WIDTH];
      and_red = and_red & s1_data_q[k*WIDTH +: WIDTH];
      xor_red = xor_red ^ s1_data_q[k*WIDTH +: WIDTH];
    end
    case (s1_op_q)
      OP_OR:   result = or_red;
      OP_AND:  result = and_red;
      OP_XOR:  result = xor_red;
      OP_NOR:  result = ~or_red;
      default: result = or_red;
    endcase
  end

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv;
    s2_load    = s1_valid_q && s2_adv;

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_data_d  = s1_data_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d   = op_e'(in_op);
        s1_data_d = in_data;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = result;
    end

    // Saturates at all-ones rather than wrapping
    count_d = count_q;
    if (s2_valid_q && out_ready && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_OR;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      count_q    <= count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_count = count_q;

`ifdef LOGIC_OP_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (s2_load) parity_d = ^result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed self-checking bench for logic_op_pipe (default config plus a CNT_W=2 instance).
module tb_logic_op_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] out_count;
  logic        in_ready2, out_valid2;
  logic [7:0]  out_data2;
  logic [1:0]  out_count2;
`ifdef LOGIC_OP_PARITY_EN
  logic        out_parity, out_parity2;
`endif

  int checks = 0;
  int failures = 0;

  logic [1:0]  vec_op  [4];
  logic [31:0] vec_dat [4];
  logic [7:0]  vec_exp [4];

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
`ifdef LOGIC_OP_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  logic_op_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_count(out_count2)
`ifdef LOGIC_OP_PARITY_EN
    , .out_parity(out_parity2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] dat,
                               input logic ordy);
    in_valid  = v;
    in_op     = op;
    in_data   = dat;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with a transfer offered
    applyStimulus(1'b1, 2'b00, 32'hFFFFFFFF, 1'b1);
    rst_n = 1'b0;
    tick(); tick(); tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_count", 32'(out_count), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_idle_valid", 32'(out_valid), 32'h0);

    // OR then NOR on 01,02,04,08
    applyStimulus(1'b1, 2'b00, 32'h08040201, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b11, 32'h08040201, 1'b1);
    tick();
    checkOutput("or_valid", 32'(out_valid), 32'h1);
    checkOutput("or_data", 32'(out_data), 32'h0F);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    tick();
    checkOutput("nor_valid", 32'(out_valid), 32'h1);
    checkOutput("nor_data", 32'(out_data), 32'hF0);
    tick();
    checkOutput("drain_valid", 32'(out_valid), 32'h0);
    checkOutput("count_after_2", 32'(out_count), 32'd2);

    // AND then XOR on FF,F0,FF,3C
    applyStimulus(1'b1, 2'b01, 32'h3CFFF0FF, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b10, 32'h3CFFF0FF, 1'b1);
    tick();
    checkOutput("and_data", 32'(out_data), 32'h30);
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    tick();
    checkOutput("xor_data", 32'(out_data), 32'hCC);
`ifdef LOGIC_OP_PARITY_EN
    checkOutput("xor_parity", 32'(out_parity), 32'h0);
`endif
    tick();
    checkOutput("count_after_4", 32'(out_count), 32'd4);

    // Four back-to-back transfers at full rate
    vec_op[0] = 2'b00; vec_dat[0] = 32'h10203040; vec_exp[0] = 8'h70;
    vec_op[1] = 2'b01; vec_dat[1] = 32'h0F0F0F0F; vec_exp[1] = 8'h0F;
    vec_op[2] = 2'b10; vec_dat[2] = 32'hAA55AA55; vec_exp[2] = 8'h00;
    vec_op[3] = 2'b11; vec_dat[3] = 32'h01000080; vec_exp[3] = 8'h7E;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        applyStimulus(1'b1, vec_op[i], vec_dat[i], 1'b1);
        checkOutput($sformatf("stream_in_ready%0d", i), 32'(in_ready), 32'h1);
      end else begin
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
      end
      tick();
      if (i >= 1) begin
        checkOutput($sformatf("stream_valid%0d", i - 1), 32'(out_valid), 32'h1);
        checkOutput($sformatf("stream_data%0d", i - 1), 32'(out_data), 32'(vec_exp[i - 1]));
      end
    end
    tick();
    checkOutput("stream_drain_valid", 32'(out_valid), 32'h0);
    checkOutput("count_after_8", 32'(out_count), 32'd8);

    // Fresh reset, then backpressure with three inputs
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_count", 32'(out_count), 32'h0);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 2'b00, 32'h00000001, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b00, 32'h00000002, 1'b0);
    checkOutput("stall_ready_b", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b1, 2'b00, 32'h00000300, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall_in_ready%0d", i), 32'(in_ready), 32'h0);
      checkOutput($sformatf("stall_hold%0d", i), 32'(out_data), 32'h01);
      checkOutput($sformatf("stall_valid%0d", i), 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'h1);
    checkOutput("release_data_a", 32'(out_data), 32'h01);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
    checkOutput("release_data_b", 32'(out_data), 32'h02);
    tick();
    checkOutput("release_data_c", 32'(out_data), 32'h03);
    tick();
    checkOutput("release_drain", 32'(out_valid), 32'h0);
    checkOutput("release_count", 32'(out_count), 32'd3);

    // Saturating 2-bit counter, then async reset mid-stall
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k < 5) applyStimulus(1'b1, 2'b00, 32'(k + 1), 1'b1);
      else       applyStimulus(1'b0, 2'b00, 32'h0, 1'b1);
      tick();
      if (k >= 2) checkOutput($sformatf("sat_count_k%0d", k), 32'(out_count2),
                              32'((k - 1 > 3) ? 3 : k - 1));
    end
    applyStimulus(1'b1, 2'b10, 32'h000000FF, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0);
    tick();
    checkOutput("prereset_valid", 32'(out_valid2), 32'h1);
    checkOutput("prereset_data", 32'(out_data2), 32'hFF);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid2), 32'h0);
    checkOutput("async_rst_count", 32'(out_count2), 32'h0);
    checkOutput("async_rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 32'(in_ready2), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
